// File: rtl/bus_arbiter_lv1_lv2.sv
// Central LV1-LV2 bus arbiter: one registered one-hot grant across dl/il/snoop requesters,
// snoop priority with a proc starvation guard, and a forced idle turnaround between owners.
module bus_arbiter_lv1_lv2 #(
    parameter int NUM_CORES       = 4,
    parameter int SNOOP_BURST_MAX = 4,
    parameter int HOLD_MAX        = 256,
    parameter int HOLD_CNT_WID    = 9
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CORES-1:0]             bus_lv1_lv2_req_proc_dl,
    input  logic [NUM_CORES-1:0]             bus_lv1_lv2_req_proc_il,
    input  logic [NUM_CORES-1:0]             bus_lv1_lv2_req_snoop,
    output logic [NUM_CORES-1:0]             bus_lv1_lv2_gnt_proc_dl,
    output logic [NUM_CORES-1:0]             bus_lv1_lv2_gnt_proc_il,
    output logic [NUM_CORES-1:0]             bus_lv1_lv2_gnt_snoop,
    output logic                             bus_busy,
    output logic [$clog2(NUM_CORES)-1:0]     gnt_owner_id,
    output logic                             hold_timeout_err
);

    localparam int ID_W     = $clog2(NUM_CORES);
    localparam int SLOTS    = 2 * NUM_CORES;
    localparam int SLOT_W   = ID_W + 1;
    localparam int STREAK_W = $clog2(SNOOP_BURST_MAX + 1);

    localparam logic [ID_W:0]         NC_W       = (ID_W + 1)'(NUM_CORES);
    localparam logic [SLOT_W:0]       SLOTS_W    = (SLOT_W + 1)'(SLOTS);
    localparam logic [ID_W-1:0]       LAST_CORE  = ID_W'(NUM_CORES - 1);
    localparam logic [SLOT_W-1:0]     LAST_SLOT  = SLOT_W'(SLOTS - 1);
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(SNOOP_BURST_MAX);
    localparam logic [HOLD_CNT_WID-1:0] HOLD_LIM = HOLD_CNT_WID'(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_SNOOP = 2'd1,
        GNT_PROC  = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [NUM_CORES-1:0]    gnt_dl_reg, gnt_dl_next;
    logic [NUM_CORES-1:0]    gnt_il_reg, gnt_il_next;
    logic [NUM_CORES-1:0]    gnt_snp_reg, gnt_snp_next;
    logic                    busy_reg, busy_next;
    logic [ID_W-1:0]         owner_reg, owner_next;
    logic [ID_W-1:0]         snp_ptr_reg, snp_ptr_next;
    logic [SLOT_W-1:0]       proc_ptr_reg, proc_ptr_next;
    logic [STREAK_W-1:0]     streak_reg, streak_next;
    logic [HOLD_CNT_WID-1:0] hold_cnt_reg, hold_cnt_next;
    logic                    err_reg, err_next;

    // Proc slots interleave dl/il per core so round-robin walks core0.dl, core0.il, core1.dl, ...
    logic [SLOTS-1:0] proc_slots;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_slots
            assign proc_slots[2*gi]   = bus_lv1_lv2_req_proc_dl[gi];
            assign proc_slots[2*gi+1] = bus_lv1_lv2_req_proc_il[gi];
        end
    endgenerate

    logic            snp_found;
    logic [ID_W-1:0] snp_pick;
    logic [ID_W:0]   snp_sum;

    always_comb begin
        snp_found = 1'b0;
        snp_pick  = '0;
        snp_sum   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            snp_sum = {1'b0, snp_ptr_reg} + (ID_W + 1)'(i);
            if (snp_sum >= NC_W) snp_sum = snp_sum - NC_W;
            if (!snp_found && bus_lv1_lv2_req_snoop[snp_sum[ID_W-1:0]]) begin
                snp_found = 1'b1;
                snp_pick  = snp_sum[ID_W-1:0];
            end
        end
    end

    logic              proc_found;
    logic [SLOT_W-1:0] proc_pick;
    logic [SLOT_W:0]   proc_sum;

    always_comb begin
        proc_found = 1'b0;
        proc_pick  = '0;
        proc_sum   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            proc_sum = {1'b0, proc_ptr_reg} + (SLOT_W + 1)'(i);
            if (proc_sum >= SLOTS_W) proc_sum = proc_sum - SLOTS_W;
            if (!proc_found && proc_slots[proc_sum[SLOT_W-1:0]]) begin
                proc_found = 1'b1;
                proc_pick  = proc_sum[SLOT_W-1:0];
            end
        end
    end

    logic owner_req;
    assign owner_req = |(gnt_dl_reg  & bus_lv1_lv2_req_proc_dl) |
                       |(gnt_il_reg  & bus_lv1_lv2_req_proc_il) |
                       |(gnt_snp_reg & bus_lv1_lv2_req_snoop);

    always_comb begin
        state_next    = state_reg;
        gnt_dl_next   = gnt_dl_reg;
        gnt_il_next   = gnt_il_reg;
        gnt_snp_next  = gnt_snp_reg;
        owner_next    = owner_reg;
        snp_ptr_next  = snp_ptr_reg;
        proc_ptr_next = proc_ptr_reg;
        streak_next   = streak_reg;
        hold_cnt_next = hold_cnt_reg;
        err_next      = err_reg;

        case (state_reg)
            IDLE: begin
                if (snp_found && (!proc_found || streak_reg < STREAK_MAX)) begin
                    state_next             = GNT_SNOOP;
                    gnt_snp_next           = '0;
                    gnt_snp_next[snp_pick] = 1'b1;
                    owner_next             = snp_pick;
                    snp_ptr_next           = (snp_pick == LAST_CORE) ? '0 : snp_pick + 1'b1;
                    hold_cnt_next          = '0;
                    if (!proc_found)
                        streak_next = '0;
                    else if (streak_reg < STREAK_MAX)
                        streak_next = streak_reg + 1'b1;
                end else if (proc_found) begin
                    state_next    = GNT_PROC;
                    gnt_dl_next   = '0;
                    gnt_il_next   = '0;
                    if (proc_pick[0])
                        gnt_il_next[proc_pick[SLOT_W-1:1]] = 1'b1;
                    else
                        gnt_dl_next[proc_pick[SLOT_W-1:1]] = 1'b1;
                    owner_next    = proc_pick[SLOT_W-1:1];
                    proc_ptr_next = (proc_pick == LAST_SLOT) ? '0 : proc_pick + 1'b1;
                    streak_next   = '0;
                    hold_cnt_next = '0;
                end
            end
            GNT_SNOOP, GNT_PROC: begin
                if (hold_cnt_reg != '1) hold_cnt_next = hold_cnt_reg + 1'b1;
                // Flag only; the owner keeps the bus.
                if (hold_cnt_next >= HOLD_LIM) err_next = 1'b1;
                if (!owner_req) begin
                    state_next   = IDLE;
                    gnt_dl_next  = '0;
                    gnt_il_next  = '0;
                    gnt_snp_next = '0;
                end
            end
            default: begin
                state_next   = IDLE;
                gnt_dl_next  = '0;
                gnt_il_next  = '0;
                gnt_snp_next = '0;
            end
        endcase

        busy_next = |{gnt_dl_next, gnt_il_next, gnt_snp_next};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            gnt_dl_reg   <= '0;
            gnt_il_reg   <= '0;
            gnt_snp_reg  <= '0;
            busy_reg     <= 1'b0;
            owner_reg    <= '0;
            snp_ptr_reg  <= '0;
            proc_ptr_reg <= '0;
            streak_reg   <= '0;
            hold_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_dl_reg   <= gnt_dl_next;
            gnt_il_reg   <= gnt_il_next;
            gnt_snp_reg  <= gnt_snp_next;
            busy_reg     <= busy_next;
            owner_reg    <= owner_next;
            snp_ptr_reg  <= snp_ptr_next;
            proc_ptr_reg <= proc_ptr_next;
            streak_reg   <= streak_next;
            hold_cnt_reg <= hold_cnt_next;
            err_reg      <= err_next;
        end
    end

    assign bus_lv1_lv2_gnt_proc_dl = gnt_dl_reg;
    assign bus_lv1_lv2_gnt_proc_il = gnt_il_reg;
    assign bus_lv1_lv2_gnt_snoop   = gnt_snp_reg;
    assign bus_busy                = busy_reg;
    assign gnt_owner_id            = owner_reg;
    assign hold_timeout_err        = err_reg;

endmodule

// File: tb/tb_bus_arbiter_lv1_lv2.sv
// Bench for bus_arbiter_lv1_lv2: directed scenarios with fixed expectations, then random
// request traffic compared cycle by cycle against a behavioural arbitration model.
module tb_bus_arbiter_lv1_lv2;

    localparam int NC        = 4;
    localparam int BURST_MAX = 4;
    localparam int HOLD_LIM  = 256;

    logic          clk;
    logic          rst_n;
    logic [NC-1:0] req_dl, req_il, req_snp;
    logic [NC-1:0] gnt_dl, gnt_il, gnt_snp;
    logic          busy;
    logic [1:0]    owner;
    logic          err;

    int tests;
    int fails;

    bus_arbiter_lv1_lv2 #(
        .NUM_CORES(NC), .SNOOP_BURST_MAX(BURST_MAX), .HOLD_MAX(HOLD_LIM), .HOLD_CNT_WID(9)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .bus_lv1_lv2_req_proc_dl (req_dl),
        .bus_lv1_lv2_req_proc_il (req_il),
        .bus_lv1_lv2_req_snoop   (req_snp),
        .bus_lv1_lv2_gnt_proc_dl (gnt_dl),
        .bus_lv1_lv2_gnt_proc_il (gnt_il),
        .bus_lv1_lv2_gnt_snoop   (gnt_snp),
        .bus_busy                (busy),
        .gnt_owner_id            (owner),
        .hold_timeout_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the bus (kind 0 none, 1 snoop, 2 dl, 3 il), plus fairness state.
    typedef struct {
        int kind;
        int core;
        int snp_ptr;
        int proc_ptr;
        int streak;
        int hold;
        bit err;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t cur, logic [NC-1:0] dl, logic [NC-1:0] il,
                                          logic [NC-1:0] snp);
        model_t n = cur;
        bit any_s = |snp;
        bit any_p = (|dl) || (|il);
        if (cur.kind == 0) begin
            if (any_s && (!any_p || cur.streak < BURST_MAX)) begin
                for (int off = 0; off < NC; off++) begin
                    int c = (cur.snp_ptr + off) % NC;
                    if (n.kind == 0 && snp[c]) begin
                        n.kind    = 1;
                        n.core    = c;
                        n.snp_ptr = (c + 1) % NC;
                        n.streak  = any_p ? ((cur.streak < BURST_MAX) ? cur.streak + 1 : BURST_MAX) : 0;
                        n.hold    = 0;
                    end
                end
            end else if (any_p) begin
                for (int off = 0; off < 2 * NC; off++) begin
                    int s = (cur.proc_ptr + off) % (2 * NC);
                    bit r = (s % 2 == 1) ? il[s/2] : dl[s/2];
                    if (n.kind == 0 && r) begin
                        n.kind     = (s % 2 == 1) ? 3 : 2;
                        n.core     = s / 2;
                        n.proc_ptr = (s + 1) % (2 * NC);
                        n.streak   = 0;
                        n.hold     = 0;
                    end
                end
            end
        end else begin
            bit still;
            if (cur.kind == 1)      still = snp[cur.core];
            else if (cur.kind == 2) still = dl[cur.core];
            else                    still = il[cur.core];
            n.hold = (cur.hold < 511) ? cur.hold + 1 : 511;
            if (n.hold >= HOLD_LIM) n.err = 1'b1;
            if (!still) n.kind = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{0, 0, 0, 0, 0, 0, 1'b0};
        else        m <= model_next(m, req_dl, req_il, req_snp);
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        req_dl  = '0;
        req_il  = '0;
        req_snp = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({gnt_dl, gnt_il, gnt_snp, busy, owner, err} !== 17'b0) begin
            fails++;
            $display("FAIL reset_state: got dl=%b il=%b snp=%b busy=%b owner=%0d err=%b, want all 0",
                     gnt_dl, gnt_il, gnt_snp, busy, owner, err);
        end
    endtask

    task automatic test_single_proc();
        do_reset();
        req_dl = 4'b0100;
        @(negedge clk);
        tests++;
        if (gnt_dl !== 4'b0100 || gnt_il !== 4'b0 || gnt_snp !== 4'b0 || busy !== 1'b1 || owner !== 2'd2) begin
            fails++;
            $display("FAIL single_grant: got dl=%b il=%b snp=%b busy=%b owner=%0d, want dl=0100 busy=1 owner=2",
                     gnt_dl, gnt_il, gnt_snp, busy, owner);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (gnt_dl !== 4'b0100) begin
            fails++;
            $display("FAIL single_hold: got dl=%b, want 0100", gnt_dl);
        end
        req_dl = 4'b0;
        @(negedge clk);
        tests++;
        if (gnt_dl !== 4'b0 || busy !== 1'b0 || owner !== 2'd2) begin
            fails++;
            $display("FAIL single_release: got dl=%b busy=%b owner=%0d, want dl=0000 busy=0 owner=2",
                     gnt_dl, busy, owner);
        end
    endtask

    task automatic test_proc_rr();
        do_reset();
        req_dl = 4'b1111;
        req_il = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            int e = i % 8;
            logic [NC-1:0] exp_dl, exp_il;
            exp_dl = '0;
            exp_il = '0;
            if (e % 2 == 0) exp_dl[e/2] = 1'b1;
            else            exp_il[e/2] = 1'b1;
            @(negedge clk);
            tests++;
            if (gnt_dl !== exp_dl || gnt_il !== exp_il || gnt_snp !== 4'b0 || owner !== 2'(e / 2)) begin
                fails++;
                $display("FAIL proc_rr grant %0d: got dl=%b il=%b snp=%b owner=%0d, want dl=%b il=%b owner=%0d",
                         i, gnt_dl, gnt_il, gnt_snp, owner, exp_dl, exp_il, e / 2);
            end
            if (e % 2 == 0) req_dl[e/2] = 1'b0;
            else            req_il[e/2] = 1'b0;
            @(negedge clk);
            tests++;
            if ({gnt_dl, gnt_il, gnt_snp, busy} !== 13'b0) begin
                fails++;
                $display("FAIL proc_rr dead %0d: got dl=%b il=%b snp=%b busy=%b, want idle",
                         i, gnt_dl, gnt_il, gnt_snp, busy);
            end
            req_dl = 4'b1111;
            req_il = 4'b1111;
        end
    endtask

    task automatic test_snoop_burst();
        do_reset();
        req_snp = 4'b0010;
        req_dl  = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            bit want_proc = (i == BURST_MAX);
            @(negedge clk);
            tests++;
            if (want_proc ? (gnt_dl !== 4'b0001 || gnt_snp !== 4'b0)
                          : (gnt_snp !== 4'b0010 || gnt_dl !== 4'b0)) begin
                fails++;
                $display("FAIL snoop_burst grant %0d: got dl=%b snp=%b, want %s",
                         i, gnt_dl, gnt_snp, want_proc ? "dl=0001" : "snp=0010");
            end
            if (want_proc) req_dl = 4'b0;
            else           req_snp = 4'b0;
            @(negedge clk);
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL snoop_burst dead %0d: got busy=%b, want 0", i, busy);
            end
            req_snp = 4'b0010;
            req_dl  = 4'b0001;
        end
    endtask

    task automatic test_snoop_priority();
        do_reset();
        req_snp = 4'b1000;
        req_il  = 4'b0010;
        @(negedge clk);
        tests++;
        if (gnt_snp !== 4'b1000 || gnt_il !== 4'b0 || owner !== 2'd3) begin
            fails++;
            $display("FAIL snoop_priority first: got snp=%b il=%b owner=%0d, want snp=1000 owner=3",
                     gnt_snp, gnt_il, owner);
        end
        req_snp = 4'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL snoop_priority dead: got busy=%b, want 0", busy);
        end
        @(negedge clk);
        tests++;
        if (gnt_il !== 4'b0010 || gnt_snp !== 4'b0 || owner !== 2'd1) begin
            fails++;
            $display("FAIL snoop_priority second: got il=%b snp=%b owner=%0d, want il=0010 owner=1",
                     gnt_il, gnt_snp, owner);
        end
        req_il = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_hold_timeout();
        do_reset();
        req_dl = 4'b0001;
        @(negedge clk);
        repeat (HOLD_LIM - 1) @(negedge clk);
        tests++;
        if (err !== 1'b0 || gnt_dl !== 4'b0001) begin
            fails++;
            $display("FAIL hold_before_limit: got err=%b dl=%b, want err=0 dl=0001", err, gnt_dl);
        end
        @(negedge clk);
        tests++;
        if (err !== 1'b1 || gnt_dl !== 4'b0001) begin
            fails++;
            $display("FAIL hold_at_limit: got err=%b dl=%b, want err=1 dl=0001", err, gnt_dl);
        end
        repeat (300 - HOLD_LIM - 1) @(negedge clk);
        req_dl = 4'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (err !== 1'b1 || gnt_dl !== 4'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_sticky: got err=%b dl=%b busy=%b, want err=1 dl=0000 busy=0", err, gnt_dl, busy);
        end
        do_reset();
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL hold_cleared: got err=%b, want 0", err);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req_snp = 4'b0100;
        @(negedge clk);
        tests++;
        if (gnt_snp !== 4'b0100) begin
            fails++;
            $display("FAIL midreset_pre: got snp=%b, want 0100", gnt_snp);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({gnt_dl, gnt_il, gnt_snp, busy, owner, err} !== 17'b0) begin
            fails++;
            $display("FAIL midreset_async: got snp=%b busy=%b owner=%0d, want all 0", gnt_snp, busy, owner);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (gnt_snp !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_regrant: got snp=%b owner=%0d busy=%b, want snp=0100 owner=2 busy=1",
                     gnt_snp, owner, busy);
        end
        req_snp = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [NC-1:0] e_dl, e_il, e_snp;
            e_dl  = '0;
            e_il  = '0;
            e_snp = '0;
            if (m.kind == 1) e_snp[m.core] = 1'b1;
            if (m.kind == 2) e_dl[m.core]  = 1'b1;
            if (m.kind == 3) e_il[m.core]  = 1'b1;
            tests++;
            if (gnt_dl !== e_dl || gnt_il !== e_il || gnt_snp !== e_snp || busy !== (m.kind != 0) ||
                owner !== 2'(m.core) || err !== m.err) begin
                fails++;
                $display("FAIL random cycle %0d: got dl=%b il=%b snp=%b busy=%b owner=%0d err=%b, want dl=%b il=%b snp=%b busy=%b owner=%0d err=%b",
                         cyc, gnt_dl, gnt_il, gnt_snp, busy, owner, err,
                         e_dl, e_il, e_snp, m.kind != 0, m.core, m.err);
            end
            for (int b = 0; b < NC; b++) begin
                if ($urandom_range(0, 3) == 0) req_dl[b]  = ~req_dl[b];
                if ($urandom_range(0, 3) == 0) req_il[b]  = ~req_il[b];
                if ($urandom_range(0, 3) == 0) req_snp[b] = ~req_snp[b];
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        req_dl  = '0;
        req_il  = '0;
        req_snp = '0;
        @(negedge clk);
        test_reset();
        test_single_proc();
        test_proc_rr();
        test_snoop_burst();
        test_snoop_priority();
        test_hold_timeout();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
